// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcodes, ALU op codes, multicycle states and mux selects.
// Imported by the pipeline decoder and the multicycle controller.
package mips_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned STATE_W  = 4;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_ADDI  = 6'b001000;
    localparam opcode_t OP_SLTI  = 6'b001010;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SW    = 6'b101011;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010,
        ALU_ADDI  = 3'b011,
        ALU_SLTI  = 3'b100
    } alu_op_t;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BEQ_EXEC = 4'd8,
        I_EXEC   = 4'd9,
        I_WB     = 4'd10
    } state_t;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        alu_op_t    aluOp;
        logic [1:0] pcSource;
    } ctrl_t;

    // Opcodes the controller knows how to sequence.
    function automatic logic isLegal(input opcode_t op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_SLTI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the shared datapath/memory.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned OP_W  = 6
);
    logic [OP_W-1:0]  instr_op_i;
    logic             mem_ready_i;
    logic             PCWrite_o;
    logic             PCWriteCond_o;
    logic             IorD_o;
    logic             MemRead_o;
    logic             MemWrite_o;
    logic             IRWrite_o;
    logic             MemtoReg_o;
    logic             RegDst_o;
    logic             RegWrite_o;
    logic             ALUSrcA_o;
    logic [1:0]       ALUSrcB_o;
    logic [2:0]       ALU_op_o;
    logic [1:0]       PCSource_o;
    logic [3:0]       state_o;
    logic             illegal_o;
    logic [CNT_W-1:0] retired_o;

    modport master (
        input  instr_op_i, mem_ready_i,
        output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
               MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o,
               PCSource_o, state_o, illegal_o, retired_o
    );

    modport slave (
        output instr_op_i, mem_ready_i,
        input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
               MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o,
               PCSource_o, state_o, illegal_o, retired_o
    );
endinterface

// File: rtl/multicycle_ctrl_out.sv
// Combinational datapath control decode from the current state, opcode and memory ready.
import mips_ctrl_pkg::*;

module multicycle_ctrl_out (
    input  state_t  state,
    input  opcode_t opcode,
    input  logic    memReady,
    input  logic    rst,
    output ctrl_t   ctrl
);

    always_comb begin
        ctrl          = '0;
        ctrl.aluSrcB  = SRCB_REG;
        ctrl.aluOp    = ALU_ADD;
        ctrl.pcSource = PCSRC_ALU;

        case (state)
            FETCH: begin
                ctrl.memRead = 1'b1;
                ctrl.aluSrcB = SRCB_FOUR;
                ctrl.irWrite = memReady;
                ctrl.pcWrite = memReady;
            end
            // Speculatively compute the branch target into ALUOut.
            DECODE: begin
                ctrl.aluSrcB = SRCB_IMM_SH2;
            end
            MEM_ADDR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
            end
            MEM_RD: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            MEM_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memtoReg = 1'b1;
            end
            MEM_WR: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            R_EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluOp   = ALU_FUNCT;
            end
            R_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b1;
            end
            BEQ_EXEC: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluOp       = ALU_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PCSRC_ALUOUT;
            end
            I_EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = (opcode == OP_SLTI) ? ALU_SLTI : ALU_ADDI;
            end
            I_WB: begin
                ctrl.regWrite = 1'b1;
            end
            default: ;
        endcase

        // No side effect on PC, IR, memory or register file while reset is held.
        if (rst) begin
            ctrl.pcWrite     = 1'b0;
            ctrl.pcWriteCond = 1'b0;
            ctrl.memRead     = 1'b0;
            ctrl.memWrite    = 1'b0;
            ctrl.irWrite     = 1'b0;
            ctrl.regWrite    = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main control FSM: state sequencing, sticky illegal-opcode flag
// and retired-instruction counter; output decode lives in multicycle_ctrl_out.
import mips_ctrl_pkg::*;

module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned OP_W  = 6
) (
    input logic               clk_i,
    input logic               rst_i,
    multicycle_ctrl_if.master bus
);

    state_t           state;
    state_t           stateNext;
    logic             retire;
    logic             illegalSet;
    logic             illegalQ;
    logic [CNT_W-1:0] retiredQ;
    logic [OP_W-1:0]  instrOp;
    opcode_t          opcode;
    ctrl_t            ctrl;

    assign instrOp = bus.instr_op_i;
    assign opcode  = OPCODE_W'(instrOp);

    // Next state, retire and illegal-opcode detection.
    always_comb begin
        stateNext  = FETCH;
        retire     = 1'b0;
        illegalSet = 1'b0;
        case (state)
            FETCH:    stateNext = bus.mem_ready_i ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:       stateNext = R_EXEC;
                    OP_LW, OP_SW:   stateNext = MEM_ADDR;
                    OP_BEQ:         stateNext = BEQ_EXEC;
                    OP_ADDI,
                    OP_SLTI:        stateNext = I_EXEC;
                    default: begin
                        stateNext  = FETCH;
                        illegalSet = !isLegal(opcode);
                    end
                endcase
            end
            MEM_ADDR: stateNext = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   stateNext = bus.mem_ready_i ? MEM_WB : MEM_RD;
            MEM_WB: begin
                stateNext = FETCH;
                retire    = 1'b1;
            end
            MEM_WR: begin
                stateNext = bus.mem_ready_i ? FETCH : MEM_WR;
                retire    = bus.mem_ready_i;
            end
            R_EXEC:   stateNext = R_WB;
            R_WB: begin
                stateNext = FETCH;
                retire    = 1'b1;
            end
            BEQ_EXEC: begin
                stateNext = FETCH;
                retire    = 1'b1;
            end
            I_EXEC:   stateNext = I_WB;
            I_WB: begin
                stateNext = FETCH;
                retire    = 1'b1;
            end
            default:  stateNext = FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= FETCH;
            illegalQ <= 1'b0;
            retiredQ <= '0;
        end else begin
            state <= stateNext;
            if (illegalSet) begin
                illegalQ <= 1'b1;
            end
            if (retire) begin
                retiredQ <= retiredQ + CNT_W'(1);
            end
        end
    end

    multicycle_ctrl_out uOut (
        .state    (state),
        .opcode   (opcode),
        .memReady (bus.mem_ready_i),
        .rst      (rst_i),
        .ctrl     (ctrl)
    );

    assign bus.PCWrite_o     = ctrl.pcWrite;
    assign bus.PCWriteCond_o = ctrl.pcWriteCond;
    assign bus.IorD_o        = ctrl.iorD;
    assign bus.MemRead_o     = ctrl.memRead;
    assign bus.MemWrite_o    = ctrl.memWrite;
    assign bus.IRWrite_o     = ctrl.irWrite;
    assign bus.MemtoReg_o    = ctrl.memtoReg;
    assign bus.RegDst_o      = ctrl.regDst;
    assign bus.RegWrite_o    = ctrl.regWrite;
    assign bus.ALUSrcA_o     = ctrl.aluSrcA;
    assign bus.ALUSrcB_o     = ctrl.aluSrcB;
    assign bus.ALU_op_o      = ctrl.aluOp;
    assign bus.PCSource_o    = ctrl.pcSource;
    assign bus.state_o       = state;
    assign bus.illegal_o     = illegalQ;
    assign bus.retired_o     = retiredQ;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: a 32-bit counter instance for the sequencing
// scenarios and a 4-bit counter instance sharing the same stimulus for the wrap case.
module tb_multicycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] instrOp;
    logic       memReady;
    int         checks = 0;
    int         errors = 0;
    int         expRet = 0;

    multicycle_ctrl_if #(.CNT_W(32), .OP_W(6)) ifM ();
    multicycle_ctrl_if #(.CNT_W(4),  .OP_W(6)) ifW ();

    assign ifM.instr_op_i  = instrOp;
    assign ifM.mem_ready_i = memReady;
    assign ifW.instr_op_i  = instrOp;
    assign ifW.mem_ready_i = memReady;

    multicycle_ctrl #(.CNT_W(32), .OP_W(6)) dut  (.clk_i(clk_i), .rst_i(rst_i), .bus(ifM));
    multicycle_ctrl #(.CNT_W(4),  .OP_W(6)) dutW (.clk_i(clk_i), .rst_i(rst_i), .bus(ifW));

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_i    = 1'b1;
        memReady = 1'b1;
        instrOp  = 6'b000000;
        tick();
        tick();
        checks++; if (ifM.state_o !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", ifM.state_o); end
        checks++; if ({ifM.MemRead_o, ifM.IRWrite_o, ifM.PCWrite_o} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {ifM.MemRead_o, ifM.IRWrite_o, ifM.PCWrite_o}); end
        rst_i = 1'b0;
        #1;
        checks++; if (ifM.retired_o !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", ifM.retired_o); end
        checks++; if (ifM.illegal_o !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", ifM.illegal_o); end
        checks++; if ({ifM.MemRead_o, ifM.IRWrite_o, ifM.ALUSrcB_o} !== 4'b1101) begin errors++; $display("FAIL fetch_outputs: got %b expected 1101", {ifM.MemRead_o, ifM.IRWrite_o, ifM.ALUSrcB_o}); end
        memReady = 1'b0;
        #1;
    endtask

    task automatic test_rtype;
        int expState [4] = '{0, 1, 6, 7};
        instrOp  = 6'b000000;
        memReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (ifM.state_o !== 4'(expState[i])) begin errors++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, ifM.state_o, expState[i]); end
            checks++; if ({ifM.RegWrite_o, ifM.RegDst_o} !== ((i == 3) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL rtype_regwrite[%0d]: got %b", i, {ifM.RegWrite_o, ifM.RegDst_o}); end
            if (i == 2) begin
                checks++; if (ifM.ALU_op_o !== 3'b010) begin errors++; $display("FAIL rtype_aluop: got %b expected 010", ifM.ALU_op_o); end
            end
            tick();
        end
        expRet++;
        checks++; if (ifM.state_o !== 4'd0) begin errors++; $display("FAIL rtype_end_state: got %0d expected 0", ifM.state_o); end
        checks++; if (ifM.retired_o !== 32'(expRet)) begin errors++; $display("FAIL rtype_retired: got %0d expected %0d", ifM.retired_o, expRet); end
    endtask

    task automatic test_lw_stalls;
        logic rdy      [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int   expState [10] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
        int   irPulses = 0;
        instrOp = 6'b100011;
        for (int i = 0; i < 10; i++) begin
            memReady = rdy[i];
            #1;
            checks++; if (ifM.state_o !== 4'(expState[i])) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, ifM.state_o, expState[i]); end
            if (ifM.IRWrite_o === 1'b1) irPulses++;
            if (expState[i] == 3) begin
                checks++; if ({ifM.MemRead_o, ifM.IorD_o} !== 2'b11) begin errors++; $display("FAIL lw_memrd[%0d]: got %b expected 11", i, {ifM.MemRead_o, ifM.IorD_o}); end
            end
            if (expState[i] == 4) begin
                checks++; if ({ifM.RegWrite_o, ifM.MemtoReg_o, ifM.RegDst_o} !== 3'b110) begin errors++; $display("FAIL lw_memwb: got %b expected 110", {ifM.RegWrite_o, ifM.MemtoReg_o, ifM.RegDst_o}); end
            end
            tick();
        end
        expRet++;
        checks++; if (irPulses != 1) begin errors++; $display("FAIL lw_irwrite_pulses: got %0d expected 1", irPulses); end
        checks++; if (ifM.state_o !== 4'd0) begin errors++; $display("FAIL lw_end_state: got %0d expected 0", ifM.state_o); end
        checks++; if (ifM.retired_o !== 32'(expRet)) begin errors++; $display("FAIL lw_retired: got %0d expected %0d", ifM.retired_o, expRet); end
    endtask

    task automatic test_sw_beq;
        logic [5:0] ops      [7] = '{6'b101011, 6'b101011, 6'b101011, 6'b101011, 6'b000100, 6'b000100, 6'b000100};
        int         expState [7] = '{0, 1, 2, 5, 0, 1, 8};
        memReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            instrOp = ops[i];
            #1;
            checks++; if (ifM.state_o !== 4'(expState[i])) begin errors++; $display("FAIL swbeq_state[%0d]: got %0d expected %0d", i, ifM.state_o, expState[i]); end
            if (expState[i] == 5) begin
                checks++; if ({ifM.MemWrite_o, ifM.IorD_o, ifM.MemRead_o} !== 3'b110) begin errors++; $display("FAIL sw_memwr: got %b expected 110", {ifM.MemWrite_o, ifM.IorD_o, ifM.MemRead_o}); end
            end
            if (expState[i] == 8) begin
                checks++; if ({ifM.PCWriteCond_o, ifM.PCSource_o, ifM.ALU_op_o, ifM.PCWrite_o} !== 7'b1_01_001_0) begin errors++; $display("FAIL beq_exec: got %b expected 1010010", {ifM.PCWriteCond_o, ifM.PCSource_o, ifM.ALU_op_o, ifM.PCWrite_o}); end
            end
            tick();
        end
        expRet += 2;
        checks++; if (ifM.retired_o !== 32'(expRet)) begin errors++; $display("FAIL swbeq_retired: got %0d expected %0d", ifM.retired_o, expRet); end
    endtask

    task automatic test_illegal;
        memReady = 1'b1;
        instrOp  = 6'b111111;
        #1;
        checks++; if (ifM.illegal_o !== 1'b0) begin errors++; $display("FAIL illegal_pre: got %b expected 0", ifM.illegal_o); end
        tick();
        checks++; if (ifM.state_o !== 4'd1) begin errors++; $display("FAIL illegal_decode: got %0d expected 1", ifM.state_o); end
        tick();
        checks++; if (ifM.state_o !== 4'd0) begin errors++; $display("FAIL illegal_to_fetch: got %0d expected 0", ifM.state_o); end
        checks++; if (ifM.illegal_o !== 1'b1) begin errors++; $display("FAIL illegal_set: got %b expected 1", ifM.illegal_o); end
        checks++; if (ifM.retired_o !== 32'(expRet)) begin errors++; $display("FAIL illegal_no_retire: got %0d expected %0d", ifM.retired_o, expRet); end
        // ADDI then SLTI, each FETCH, DECODE, I_EXEC, I_WB.
        for (int k = 0; k < 2; k++) begin
            instrOp = (k == 0) ? 6'b001000 : 6'b001010;
            tick();
            tick();
            checks++; if (ifM.state_o !== 4'd9) begin errors++; $display("FAIL iexec_state[%0d]: got %0d expected 9", k, ifM.state_o); end
            checks++; if (ifM.ALU_op_o !== ((k == 0) ? 3'b011 : 3'b100)) begin errors++; $display("FAIL iexec_aluop[%0d]: got %b", k, ifM.ALU_op_o); end
            tick();
            checks++; if ({ifM.state_o, ifM.RegWrite_o, ifM.RegDst_o, ifM.MemtoReg_o} !== 7'b1010_100) begin errors++; $display("FAIL iwb[%0d]: got %b expected 1010100", k, {ifM.state_o, ifM.RegWrite_o, ifM.RegDst_o, ifM.MemtoReg_o}); end
            tick();
            expRet++;
            checks++; if (ifM.retired_o !== 32'(expRet)) begin errors++; $display("FAIL i_retired[%0d]: got %0d expected %0d", k, ifM.retired_o, expRet); end
            checks++; if (ifM.illegal_o !== 1'b1) begin errors++; $display("FAIL illegal_sticky[%0d]: got %b expected 1", k, ifM.illegal_o); end
        end
    endtask

    task automatic test_reset_mid;
        instrOp  = 6'b100011;
        memReady = 1'b1;
        tick();
        tick();
        tick();
        memReady = 1'b0;
        #1;
        checks++; if ({ifM.state_o, ifM.MemRead_o} !== 5'b0011_1) begin errors++; $display("FAIL mid_memrd: got %b expected 00111", {ifM.state_o, ifM.MemRead_o}); end
        rst_i = 1'b1;
        #1;
        checks++; if (ifM.MemRead_o !== 1'b0) begin errors++; $display("FAIL mid_rst_gate: got %b expected 0", ifM.MemRead_o); end
        memReady = 1'b1;
        tick();
        checks++; if ({ifM.state_o, ifM.MemRead_o, ifM.IRWrite_o, ifM.PCWrite_o} !== 7'b0000_000) begin errors++; $display("FAIL mid_rst_fetch: got %b expected 0000000", {ifM.state_o, ifM.MemRead_o, ifM.IRWrite_o, ifM.PCWrite_o}); end
        tick();
        rst_i    = 1'b0;
        memReady = 1'b0;
        expRet   = 0;
        #1;
        checks++; if (ifM.state_o !== 4'd0) begin errors++; $display("FAIL mid_state: got %0d expected 0", ifM.state_o); end
        checks++; if (ifM.retired_o !== 32'd0) begin errors++; $display("FAIL mid_retired: got %0d expected 0", ifM.retired_o); end
        checks++; if (ifM.illegal_o !== 1'b0) begin errors++; $display("FAIL mid_illegal: got %b expected 0", ifM.illegal_o); end
    endtask

    task automatic test_back_to_back;
        instrOp  = 6'b000100;
        memReady = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            tick();
            tick();
            if (k == 15) begin
                checks++; if (ifW.retired_o !== 4'd15) begin errors++; $display("FAIL wrap_15: got %0d expected 15", ifW.retired_o); end
            end
        end
        checks++; if (ifW.retired_o !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", ifW.retired_o); end
        checks++; if (ifM.retired_o !== 32'd16) begin errors++; $display("FAIL wide_16: got %0d expected 16", ifM.retired_o); end
        checks++; if (ifW.state_o !== 4'd0) begin errors++; $display("FAIL wrap_state: got %0d expected 0", ifW.state_o); end
    endtask

    initial begin
        rst_i    = 1'b1;
        memReady = 1'b0;
        instrOp  = 6'b000000;
        test_reset();
        test_rtype();
        test_lw_stalls();
        test_sw_beq();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle variant of the MIPS CPU. It sequences the shared datapath: one memory port, one ALU, and the IR, A, B and ALUOut registers. Each instruction runs through FETCH/DECODE/EXEC/MEM/WB steps, with wait states on a memory-ready handshake. It supports the same opcode set as the pipeline decoder: R-type, ADDI, SLTI, LW, SW and BEQ.

Parameters:
CNT_W, 32, width of the retired-instruction counter
OP_W, 6, opcode field width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
instr_op_i  in  6  opcode from the IR (IR[31:26]), valid from DECODE onward
mem_ready_i  in  1  memory completes the current read/write this cycle
PCWrite_o  out  1  unconditional PC load
PCWriteCond_o  out  1  PC load if ALU zero
IorD_o  out  1  memory address select: 0=PC, 1=ALUOut
MemRead_o  out  1  memory read request
MemWrite_o  out  1  memory write request
IRWrite_o  out  1  IR load
MemtoReg_o  out  1  register write data: 0=ALUOut, 1=MDR
RegDst_o  out  1  destination register: 0=rt, 1=rd
RegWrite_o  out  1  register file write
ALUSrcA_o  out  1  ALU A input: 0=PC, 1=A register
ALUSrcB_o  out  2  ALU B input: 00=B, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
ALU_op_o  out  3  000 add, 001 sub(BEQ), 010 R-type funct, 011 ADDI, 100 SLTI
PCSource_o  out  2  PC source: 00=ALU result, 01=ALUOut
state_o  out  4  current state encoding, for debug
illegal_o  out  1  sticky flag: an unsupported opcode was decoded
retired_o  out  CNT_W  count of completed instructions

Behaviour:
- Clock and reset: one clock, clk_i; reset is synchronous and active-high on rst_i.
- Reset values: state=FETCH(0), retired_o=0, illegal_o=0.
- While rst_i=1, all strobes are forced 0: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite.
- Output timing: outputs are combinational from the state and mem_ready_i. Any output not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BEQ_EXEC=8, I_EXEC=9, I_WB=10. Codes 11-15 are unused; any unused code returns to FETCH on the next edge.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=000, PCSource=00.
  - IRWrite and PCWrite = mem_ready_i.
  - Stay in FETCH while mem_ready_i=0; go to DECODE when it is 1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALU_op=000 (branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC
  - LW (100011) or SW (101011) -> MEM_ADDR
  - BEQ (000100) -> BEQ_EXEC
  - ADDI (001000) or SLTI (001010) -> I_EXEC
  - any other opcode -> FETCH, and illegal_o is set (sticky until reset). No retire.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALU_op=000. Go to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: MemRead=1, IorD=1. Wait for mem_ready_i, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Go to FETCH.
- MEM_WR: MemWrite=1, IorD=1. Wait for mem_ready_i, then go to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALU_op=010. Go to R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Go to FETCH.
- BEQ_EXEC: ALUSrcA=1, ALUSrcB=00, ALU_op=001, PCWriteCond=1, PCSource=01. Go to FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALU_op=011 for ADDI or 100 for SLTI. Go to I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0. The opcode is held stable by the IR. Go to FETCH.
- Retire counting:
  - retired_o increments by 1 on the edge that leaves MEM_WB, R_WB, BEQ_EXEC or I_WB.
  - It also increments on the edge leaving MEM_WR when mem_ready_i=1.
  - It wraps modulo 2^CNT_W.
- Latency with mem_ready_i held at 1:
  - R-type, ADDI, SLTI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - Each cycle with mem_ready_i=0 in a memory state adds one cycle.
- Reset mid-operation: rst_i wins over every transition. The cycle after reset is FETCH with a clean counter, and no strobe is asserted while rst_i=1.
- mem_ready_i is ignored in non-memory states.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ);
  - ALU_op encodings, shared with the pipeline decoder;
  - the state encoding;
  - the ALUSrcB and PCSource select constants.
- A single sub-module, multicycle_ctrl_out, is natural: it is the combinational output decode from state, opcode and mem_ready_i. The next-state register and the counter stay in the top level.

Test Plan:
- Reset: hold rst_i for 2 cycles during MEM_RD -> state_o=0, retired_o=0, illegal_o=0, all strobes 0 while reset is high.
- R-type (op=0), mem_ready_i=1: state_o sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; retired_o=1.
- LW with 2 FETCH stalls and 3 MEM_RD stalls: IRWrite pulses once, when ready; 10 cycles total; MemtoReg=1 in MEM_WB; retired_o increments once.
- SW followed by BEQ: MemWrite=1 with IorD=1 in MEM_WR; BEQ_EXEC drives PCWriteCond=1, PCSource=01, ALU_op=001; retired_o=2 after 7 cycles.
- Illegal opcode 6'b111111: DECODE -> FETCH; illegal_o=1 and stays 1 through a following ADDI; retired_o counts only the ADDI; I_EXEC drives ALU_op=011.
- Counter wrap with CNT_W=4: 16 back-to-back BEQs -> retired_o returns to 0.
